spi_alu_cmd_rx: RTL and testbench

SPI mode-0 slave front-end that receives one ALU command frame (command byte, operand 1, operand 2) per chip-select assertion. It presents the decoded frame to the ALU input stage as a single-cycle valid pulse. The block sits directly upstream of the ALU and drives its valid_i, data_i_1, data_i_2 and sel_i. All SPI inputs are oversampled in the clk domain.

---
 rtl/spi_alu_cmd_rx.sv | 136 +++++++++++++
 tb/tb_spi_alu_cmd_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_alu_cmd_rx.sv
`timescale 1ns/1ps
// spi_alu_cmd_rx: SPI mode-0 slave that receives one 3-byte ALU command frame (cmd, op1, op2) per chip-select assertion.
// Latency: valid_o pulses 1 clk after the sampled SCLK rise that completes operand 2 (SYNC_STAGES+2 clk after the pin edge, +/-1).
// Backpressure: none; the downstream ALU accepts a frame every cycle, and SCLK is only oversampled.
//
// Ports:
//   clk, rst_n                       system clock, async active-low reset
//   spi_sclk_i, spi_cs_n_i, spi_mosi_i  raw SPI pins (asynchronous to clk)
//   valid_o                          one-cycle pulse, frame fields valid
//   data_o_1, data_o_2, sel_o        operand 1, operand 2, op select (held until next frame)
//   frame_err_o                      one-cycle pulse when a frame is aborted mid-way
module spi_alu_cmd_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int SEL_WIDTH   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_sclk_i,
    input  logic                  spi_cs_n_i,
    input  logic                  spi_mosi_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o_1,
    output logic [DATA_WIDTH-1:0] data_o_2,
    output logic [SEL_WIDTH-1:0]  sel_o,
    output logic                  frame_err_o
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, CMD, OP1, OP2, DONE} state_t;

    // Equal-depth synchronisers keep SCLK, CS and MOSI aligned to one another.
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_q      <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            sclk_q      <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s, cs_s, mosi_s, rise;
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_q;

    state_t                state_q;
    logic [CW-1:0]         bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] data1_q, data2_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic                  valid_q, err_q;

    // Byte as it will look once the current MOSI bit is shifted in.
    logic [DATA_WIDTH-1:0] byte_full;
    logic                  byte_done;
    assign byte_full = {shift_q[DATA_WIDTH-2:0], mosi_s};
    assign byte_done = rise && (bit_cnt_q == CW'(DATA_WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
            sel_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    bit_cnt_q <= '0;
                    if (!cs_s) state_q <= CMD;
                end
                CMD, OP1, OP2: begin
                    // CS release wins over a coincident SCLK rise.
                    if (cs_s) begin
                        // Releasing CS before any bit arrived is an empty select, not an error.
                        if (!(state_q == CMD && bit_cnt_q == '0)) err_q <= 1'b1;
                        state_q   <= IDLE;
                        bit_cnt_q <= '0;
                    end else if (rise) begin
                        shift_q <= byte_full;
                        if (byte_done) begin
                            bit_cnt_q <= '0;
                            case (state_q)
                                CMD: begin
                                    sel_q   <= byte_full[SEL_WIDTH-1:0];
                                    state_q <= OP1;
                                end
                                OP1: begin
                                    data1_q <= byte_full;
                                    state_q <= OP2;
                                end
                                default: begin
                                    data2_q <= byte_full;
                                    valid_q <= 1'b1;
                                    state_q <= DONE;
                                end
                            endcase
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CW'(1);
                        end
                    end
                end
                DONE: begin
                    // Extra bytes after a complete frame are dropped until CS goes high.
                    if (cs_s) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid_o     = valid_q;
    assign frame_err_o = err_q;
    assign data_o_1    = data1_q;
    assign data_o_2    = data2_q;
    assign sel_o       = sel_q;

endmodule

// File: tb/tb_spi_alu_cmd_rx.sv
`timescale 1ns/1ps
// tb_spi_alu_cmd_rx: directed SPI frames against spi_alu_cmd_rx with hand-computed expectations.
// Latency: checks valid_o timing against the driven SCLK edge within the allowed window.
// Backpressure: none; the DUT has no ready input.
module tb_spi_alu_cmd_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       valid_o, frame_err_o;
    logic [7:0] data_o_1, data_o_2;
    logic [1:0] sel_o;

    spi_alu_cmd_rx #(.DATA_WIDTH(8), .SEL_WIDTH(2), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_sclk_i (sclk),
        .spi_cs_n_i (cs_n),
        .spi_mosi_i (mosi),
        .valid_o    (valid_o),
        .data_o_1   (data_o_1),
        .data_o_2   (data_o_2),
        .sel_o      (sel_o),
        .frame_err_o(frame_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pulse monitor, sampled on the falling clk edge.
    int         vcnt = 0;
    int         ecnt = 0;
    logic [7:0] cap1 = 8'h00, cap2 = 8'h00;
    logic [1:0] capsel = 2'b00;
    time        vtime = 0;
    time        rtime = 0;

    always @(negedge clk) begin
        if (valid_o) begin
            vcnt   <= vcnt + 1;
            cap1   <= data_o_1;
            cap2   <= data_o_2;
            capsel <= sel_o;
            vtime  <= $time;
        end
        if (frame_err_o) ecnt <= ecnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            wait_clk(half);
            sclk  = 1'b1;
            rtime = $time;
            wait_clk(half);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b, input int half);
        cs_n = 1'b0;
        wait_clk(half);
        send_bits(c, 8, half);
        send_bits(a, 8, half);
        send_bits(b, 8, half);
        wait_clk(half);
        cs_n = 1'b1;
    endtask

    int v0, e0, lat;
    time r_last;

    initial begin
        // Reset state
        wait_clk(3);
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_err", 32'(frame_err_o), 32'd0);
        check("reset_data", {8'h0, sel_o, 6'h0, data_o_1, data_o_2}, 32'd0);
        rst_n = 1'b1;
        wait_clk(5);

        // Basic add frame at clk/8, plus latency window
        v0 = vcnt; e0 = ecnt;
        frame(8'h00, 8'h05, 8'h03, 4);
        r_last = rtime;
        wait_clk(20);
        check("t1_valid_cnt", 32'(vcnt - v0), 32'd1);
        check("t1_err_cnt", 32'(ecnt - e0), 32'd0);
        check("t1_capture", {14'h0, capsel, cap1, cap2}, {14'h0, 2'b00, 8'h05, 8'h03});
        lat = int'((vtime - r_last) / 10);
        check("t1_latency_window", 32'(lat >= 3 && lat <= 5), 32'd1);

        // Reserved command bits, then an extra byte in DONE
        v0 = vcnt; e0 = ecnt;
        cs_n = 1'b0;
        wait_clk(4);
        send_bits(8'hFD, 8, 4);
        send_bits(8'h80, 8, 4);
        send_bits(8'h01, 8, 4);
        send_bits(8'hAA, 8, 4);
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(20);
        check("t2_valid_cnt", 32'(vcnt - v0), 32'd1);
        check("t2_err_cnt", 32'(ecnt - e0), 32'd0);
        check("t2_capture", {14'h0, capsel, cap1, cap2}, {14'h0, 2'b01, 8'h80, 8'h01});
        check("t2_hold_after_extra", {14'h0, sel_o, data_o_1, data_o_2}, {14'h0, 2'b01, 8'h80, 8'h01});

        // Abort after 12 bits
        v0 = vcnt; e0 = ecnt;
        cs_n = 1'b0;
        wait_clk(4);
        send_bits(8'h02, 8, 4);
        send_bits(8'h70, 4, 4);
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(20);
        check("t3_abort_err_cnt", 32'(ecnt - e0), 32'd1);
        check("t3_abort_valid_cnt", 32'(vcnt - v0), 32'd0);
        v0 = vcnt; e0 = ecnt;
        frame(8'h02, 8'h10, 8'h00, 4);
        wait_clk(20);
        check("t3_recover_valid_cnt", 32'(vcnt - v0), 32'd1);
        check("t3_recover_capture", {14'h0, capsel, cap1, cap2}, {14'h0, 2'b10, 8'h10, 8'h00});

        // Empty select
        v0 = vcnt; e0 = ecnt;
        cs_n = 1'b0;
        wait_clk(12);
        cs_n = 1'b1;
        wait_clk(12);
        check("t4_empty_err_cnt", 32'(ecnt - e0), 32'd0);
        check("t4_empty_valid_cnt", 32'(vcnt - v0), 32'd0);

        // CS release coincident with the completing SCLK rise of operand 2
        v0 = vcnt; e0 = ecnt;
        cs_n = 1'b0;
        wait_clk(4);
        send_bits(8'h03, 8, 4);
        send_bits(8'h44, 8, 4);
        send_bits(8'h55, 7, 4);
        mosi = 1'b1;
        wait_clk(4);
        sclk = 1'b1;
        cs_n = 1'b1;
        wait_clk(4);
        sclk = 1'b0;
        wait_clk(20);
        check("t5_simul_err_cnt", 32'(ecnt - e0), 32'd1);
        check("t5_simul_valid_cnt", 32'(vcnt - v0), 32'd0);

        // Reset in the middle of operand 1
        v0 = vcnt; e0 = ecnt;
        cs_n = 1'b0;
        wait_clk(4);
        send_bits(8'h01, 8, 4);
        send_bits(8'h09, 5, 4);
        #2 rst_n = 1'b0;
        #1;
        check("t6_reset_outputs", {14'h0, sel_o, data_o_1, data_o_2}, 32'd0);
        check("t6_reset_pulses", {30'h0, valid_o, frame_err_o}, 32'd0);
        sclk = 1'b0;
        cs_n = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        frame(8'h01, 8'h09, 8'h04, 4);
        wait_clk(20);
        check("t6_after_reset_valid_cnt", 32'(vcnt - v0), 32'd1);
        check("t6_after_reset_err_cnt", 32'(ecnt - e0), 32'd0);
        check("t6_after_reset_capture", {14'h0, capsel, cap1, cap2}, {14'h0, 2'b01, 8'h09, 8'h04});

        // Back-to-back at clk/8 with 2 SCLK periods of CS high
        v0 = vcnt; e0 = ecnt;
        frame(8'h01, 8'h11, 8'h22, 4);
        wait_clk(16);
        frame(8'h02, 8'h33, 8'h44, 4);
        wait_clk(20);
        check("t7_b2b8_valid_cnt", 32'(vcnt - v0), 32'd2);
        check("t7_b2b8_err_cnt", 32'(ecnt - e0), 32'd0);
        check("t7_b2b8_capture", {14'h0, capsel, cap1, cap2}, {14'h0, 2'b10, 8'h33, 8'h44});

        // Back-to-back at the minimum ratio clk/4
        v0 = vcnt; e0 = ecnt;
        frame(8'h03, 8'hA5, 8'h5A, 2);
        wait_clk(8);
        frame(8'hFC, 8'hC3, 8'h3C, 2);
        wait_clk(20);
        check("t8_b2b4_valid_cnt", 32'(vcnt - v0), 32'd2);
        check("t8_b2b4_err_cnt", 32'(ecnt - e0), 32'd0);
        check("t8_b2b4_capture", {14'h0, capsel, cap1, cap2}, {14'h0, 2'b00, 8'hC3, 8'h3C});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
